crop_window: RTL and testbench

- Downstream consumer of the crop x-start detector in the image capture path.
- Takes the raw 640x480 pixel stream and the detected horizontal start (oXSTART/oDVAL of the upstream stage).
- Emits only the pixels inside a fixed-width window beginning at that column, with window-relative coordinates.
- A new start value is shadowed and applied only at the next frame boundary, so a frame is never cropped with two different offsets.

---
 rtl/crop_window.sv | 113 +++++++++++
 tb/tb_crop_window.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/crop_window.sv
// Fixed-width horizontal crop of a raster pixel stream with window-relative coordinates.
// The window start is shadowed and only applied at the frame-start pixel.
module crop_window #(
   parameter int H_ACTIVE = 640,
   parameter int V_ACTIVE = 480,
   parameter int CROP_W   = 256,
   parameter int DATA_W   = 10
) (
   input  logic              iCLK,
   input  logic              iRST,
   input  logic [DATA_W-1:0] iDATA,
   input  logic              iDVAL,
   input  logic [15:0]       iXSTART,
   input  logic              iXSTART_VAL,
   output logic [DATA_W-1:0] oDATA,
   output logic              oDVAL,
   output logic [15:0]       oX_Cont,
   output logic [15:0]       oY_Cont,
   output logic              oFRAME_DONE
);

   localparam logic [15:0] MAX_START = 16'(H_ACTIVE - CROP_W);
   localparam logic [15:0] LAST_X    = 16'(H_ACTIVE - 1);
   localparam logic [15:0] LAST_Y    = 16'(V_ACTIVE - 1);
   localparam logic [15:0] WIN_LAST  = 16'(CROP_W - 1);

   typedef enum logic {IDLE, ACTIVE} state_t;

   state_t      state, stateNext;
   logic [15:0] xIn, yIn;
   logic [15:0] pendStart, actStart;
   logic [15:0] reqClamped;
   logic [15:0] xsEff, winEnd, xRel;
   logic        frameStart;
   logic        acceptPix;
   logic        lastPix;

   assign frameStart = iDVAL && (xIn == '0) && (yIn == '0);
   assign reqClamped = (iXSTART > MAX_START) ? MAX_START : iXSTART;
   // The frame-start pixel is judged against the value being loaded, not the stale one.
   assign xsEff      = frameStart ? pendStart : actStart;
   assign winEnd     = xsEff + WIN_LAST;
   assign xRel       = xIn - xsEff;

   // State register
   always_ff @(posedge iCLK) begin
      if (!iRST) state <= IDLE;
      else       state <= stateNext;
   end

   // Next-state logic
   always_comb begin
      stateNext = state;
      case (state)
         IDLE:    if (frameStart) stateNext = ACTIVE;
         ACTIVE:  stateNext = ACTIVE;
         default: stateNext = IDLE;
      endcase
   end

   // Output decode
   always_comb begin
      acceptPix = 1'b0;
      if (iDVAL && ((state == ACTIVE) || frameStart))
         acceptPix = (xIn >= xsEff) && (xIn <= winEnd);
      lastPix = acceptPix && (xRel == WIN_LAST) && (yIn == LAST_Y);
   end

   // Input raster counters
   always_ff @(posedge iCLK) begin
      if (!iRST) begin
         xIn <= '0;
         yIn <= '0;
      end else if (iDVAL) begin
         if (xIn == LAST_X) begin
            xIn <= '0;
            yIn <= (yIn == LAST_Y) ? '0 : yIn + 16'd1;
         end else begin
            xIn <= xIn + 16'd1;
         end
      end
   end

   // Start shadowing: a same-cycle strobe lands in pending after active has been loaded
   always_ff @(posedge iCLK) begin
      if (!iRST) begin
         pendStart <= '0;
         actStart  <= '0;
      end else begin
         if (frameStart)  actStart  <= pendStart;
         if (iXSTART_VAL) pendStart <= reqClamped;
      end
   end

   always_ff @(posedge iCLK) begin
      if (!iRST) begin
         oDATA       <= '0;
         oDVAL       <= 1'b0;
         oX_Cont     <= '0;
         oY_Cont     <= '0;
         oFRAME_DONE <= 1'b0;
      end else begin
         oDVAL       <= acceptPix;
         oFRAME_DONE <= lastPix;
         if (acceptPix) begin
            oDATA   <= iDATA;
            oX_Cont <= xRel;
            oY_Cont <= yIn;
         end
      end
   end

endmodule

// File: tb/tb_crop_window.sv
// Directed bench for crop_window on a reduced 16x4 raster with a 6-pixel window.
module tb_crop_window;

   localparam int H  = 16;
   localparam int V  = 4;
   localparam int W  = 6;
   localparam int DW = 10;

   typedef struct {
      int data;
      int x;
      int y;
      int done;
   } expPix_t;

   logic          iCLK = 1'b0;
   logic          iRST = 1'b0;
   logic [DW-1:0] iDATA = '0;
   logic          iDVAL = 1'b0;
   logic [15:0]   iXSTART = '0;
   logic          iXSTART_VAL = 1'b0;
   logic [DW-1:0] oDATA;
   logic          oDVAL;
   logic [15:0]   oX_Cont;
   logic [15:0]   oY_Cont;
   logic          oFRAME_DONE;

   int checkCnt = 0;
   int errCnt   = 0;
   int outCnt   = 0;
   int doneCnt  = 0;
   int xModel   = 0;
   int yModel   = 0;
   bit inReset  = 1'b0;
   expPix_t expQ[$];

   crop_window #(.H_ACTIVE(H), .V_ACTIVE(V), .CROP_W(W), .DATA_W(DW)) dut (
      .iCLK(iCLK), .iRST(iRST), .iDATA(iDATA), .iDVAL(iDVAL),
      .iXSTART(iXSTART), .iXSTART_VAL(iXSTART_VAL),
      .oDATA(oDATA), .oDVAL(oDVAL), .oX_Cont(oX_Cont), .oY_Cont(oY_Cont),
      .oFRAME_DONE(oFRAME_DONE)
   );

   always #5 iCLK = ~iCLK;

   task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checkCnt++;
      if (obs !== exp) begin
         errCnt++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   // Output monitor: every valid output is matched against the expectation queue.
   initial begin
      expPix_t e;
      forever begin
         @(posedge iCLK);
         #1;
         if (oDVAL === 1'b1) begin
            outCnt++;
            if (oFRAME_DONE === 1'b1) doneCnt++;
            if (expQ.size() == 0) begin
               checkVal("unexpected_dval", 32'(oDVAL), 32'd0);
            end else begin
               e = expQ.pop_front();
               checkVal("data", 32'(oDATA), 32'(e.data));
               checkVal("xcont", 32'(oX_Cont), 32'(e.x));
               checkVal("ycont", 32'(oY_Cont), 32'(e.y));
               checkVal("frame_done", 32'(oFRAME_DONE), 32'(e.done));
            end
         end else if (!inReset) begin
            checkVal("done_without_dval", 32'(oFRAME_DONE), 32'd0);
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge iCLK);
         iDVAL       = 1'b0;
         iXSTART_VAL = 1'b0;
      end
   endtask

   task automatic strobe(input int v);
      @(negedge iCLK);
      iDVAL       = 1'b0;
      iXSTART_VAL = 1'b1;
      iXSTART     = 16'(v);
      idle(1);
   endtask

   // Streams numPix pixels of a frame; xsExp is the hand-derived window start for it.
   task automatic runFrame(input int xsExp, input int gap, input int stbIdx,
                           input int stbVal, input int numPix);
      expPix_t e;
      for (int i = 0; i < numPix; i++) begin
         @(negedge iCLK);
         iDVAL       = 1'b1;
         iDATA       = DW'(xModel + (yModel << 4));
         iXSTART_VAL = (i == stbIdx);
         iXSTART     = 16'(stbVal);
         if (xModel >= xsExp && xModel <= xsExp + W - 1) begin
            e.data = xModel + (yModel << 4);
            e.x    = xModel - xsExp;
            e.y    = yModel;
            e.done = (xModel - xsExp == W - 1) && (yModel == V - 1);
            expQ.push_back(e);
         end
         xModel++;
         if (xModel == H) begin
            xModel = 0;
            yModel = (yModel == V - 1) ? 0 : yModel + 1;
         end
         for (int g = 0; g < gap; g++) begin
            @(negedge iCLK);
            iDVAL       = 1'b0;
            iXSTART_VAL = 1'b0;
         end
      end
   endtask

   task automatic fullFrame(input string tag, input int xsExp, input int gap,
                            input int stbIdx, input int stbVal);
      outCnt  = 0;
      doneCnt = 0;
      runFrame(xsExp, gap, stbIdx, stbVal, H * V);
      idle(2);
      checkVal({tag, "_outcount"}, 32'(outCnt), 32'(W * V));
      checkVal({tag, "_donecount"}, 32'(doneCnt), 32'd1);
   endtask

   task automatic applyReset();
      inReset = 1'b1;
      @(negedge iCLK);
      iRST        = 1'b0;
      iXSTART_VAL = 1'b0;
      iDVAL       = 1'($urandom_range(0, 1));
      iDATA       = DW'($urandom);
      @(posedge iCLK);
      #1;
      checkVal("rst_dval_next", 32'(oDVAL), 32'd0);
      repeat (2) begin
         @(negedge iCLK);
         iDVAL = 1'($urandom_range(0, 1));
         iDATA = DW'($urandom);
      end
      @(posedge iCLK);
      #1;
      checkVal("rst_data", 32'(oDATA), 32'd0);
      checkVal("rst_dval", 32'(oDVAL), 32'd0);
      checkVal("rst_x", 32'(oX_Cont), 32'd0);
      checkVal("rst_y", 32'(oY_Cont), 32'd0);
      checkVal("rst_done", 32'(oFRAME_DONE), 32'd0);
      @(negedge iCLK);
      iRST  = 1'b1;
      iDVAL = 1'b0;
      expQ.delete();
      xModel  = 0;
      yModel  = 0;
      inReset = 1'b0;
   endtask

   initial begin
      applyReset();
      outCnt = 0;
      idle(4);
      checkVal("no_output_before_frame", 32'(outCnt), 32'd0);

      strobe(3);
      fullFrame("xs3", 3, 0, -1, 0);
      strobe(12);
      fullFrame("clamp10", 10, 0, -1, 0);
      strobe(3);
      fullFrame("midstrobe_cur", 3, 0, 1 * H + 4, 0);
      fullFrame("midstrobe_next", 0, 0, 2 * H + 8, 5);
      fullFrame("samecycle_cur", 5, 0, 0, 2);
      fullFrame("samecycle_next", 2, 0, -1, 0);
      strobe(3);
      fullFrame("gap3", 3, 2, -1, 0);

      outCnt  = 0;
      doneCnt = 0;
      runFrame(3, 0, -1, 0, 2 * H + 5);
      applyReset();
      checkVal("partial_outcount", 32'(outCnt), 32'd14);
      checkVal("partial_donecount", 32'(doneCnt), 32'd0);
      fullFrame("after_reset_xs0", 0, 0, -1, 0);

      checkVal("queue_drained", 32'(expQ.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checkCnt, errCnt);
      $finish;
   end

endmodule
